shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 145 ++++++++++++++
 tb/tb_shift_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the shift sequencer: operands in, results out.
// The clock and reset are plain ports on the sequencer and are not part of this bundle.
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [19:0] data1;
  logic [19:0] data2;
  logic [4:0]  amount;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] result1;
  logic [19:0] result2;
  logic        err;
  logic        busy;

  modport master (
    output in_valid, op, data1, data2, amount, out_ready,
    input  in_ready, out_valid, result1, result2, err, busy
  );

  modport slave (
    input  in_valid, op, data1, data2, amount, out_ready,
    output in_ready, out_valid, result1, result2, err, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 20-bit shifter/rotator that moves one bit per cycle, with SWAP and illegal-op reporting.
// Results are latched on entry to DONE and held until the consumer takes them.
module shift_sequencer (
  input logic              clk,
  input logic              rst,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHFTR = 3'd0;
  localparam logic [2:0] OP_SHFTL = 3'd1;
  localparam logic [2:0] OP_ROTR  = 3'd2;
  localparam logic [2:0] OP_ROTL  = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [2:0]  op_r, op_s;
  logic [19:0] work_r, work_s;
  logic [19:0] result1_r, result1_s;
  logic [19:0] result2_r, result2_s;
  logic        err_r, err_s;
  logic [19:0] step_s;
  logic        is_shift_op_s;
  logic        in_range_s;

  function automatic logic [19:0] shift_one(input logic [19:0] w, input logic [2:0] o);
    logic [19:0] r;
    case (o)
      OP_SHFTR: r = {1'b0, w[19:1]};
      OP_SHFTL: r = {w[18:0], 1'b0};
      OP_ROTR:  r = {w[0], w[19:1]};
      OP_ROTL:  r = {w[18:0], w[19]};
      default:  r = w;
    endcase
    return r;
  endfunction

  // Classify the incoming request and precompute the single-bit step of the work register
  always_comb begin
    is_shift_op_s = (bus.op <= OP_ROTL);
    in_range_s    = (bus.amount >= 5'd1) && (bus.amount <= 5'd19);
    step_s        = shift_one(work_r, op_r);
  end

  // Next-state and datapath decode; anything not run bit-by-bit resolves straight into DONE
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    op_s      = op_r;
    work_s    = work_r;
    result1_s = result1_r;
    result2_s = result2_r;
    err_s     = err_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          op_s   = bus.op;
          work_s = bus.data1;
          if (is_shift_op_s && in_range_s) begin
            state_s = RUN;
            cnt_s   = bus.amount;
          end else begin
            state_s = DONE;
            cnt_s   = 5'd0;
            if (is_shift_op_s) begin
              // amount 0 passes through; 20..31 empties the word for rotates too
              result1_s = (bus.amount == 5'd0) ? bus.data1 : 20'd0;
              result2_s = 20'd0;
              err_s     = 1'b0;
            end else if (bus.op == OP_SWAP) begin
              result1_s = bus.data2;
              result2_s = bus.data1;
              err_s     = 1'b0;
            end else begin
              result1_s = 20'd0;
              result2_s = 20'd0;
              err_s     = 1'b1;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        work_s = step_s;
        cnt_s  = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_s   = DONE;
          result1_s = step_s;
          result2_s = 20'd0;
          err_s     = 1'b0;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 5'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      op_r      <= 3'd0;
      work_r    <= 20'd0;
      result1_r <= 20'd0;
      result2_r <= 20'd0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      work_r    <= work_s;
      result1_r <= result1_s;
      result2_r <= result2_s;
      err_r     <= err_s;
    end
  end

  // in_ready also looks at rst so that no request is offered during the reset cycle
  assign bus.in_ready  = (state_r == IDLE) && !rst;
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.result1   = result1_r;
  assign bus.result2   = result2_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed vectors covering shifts, rotates, SWAP,
// illegal ops, out-of-range amounts, output hold, and reset abort.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   lat;
  int   seen;

  shift_sequencer_if bus();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one request, measure accept-to-out_valid latency in cycles, check the results
  task automatic issue(input string tag, input logic [2:0] o, input logic [19:0] d1, input logic [19:0] d2,
                       input logic [4:0] a, input bit hold_valid, input int exp_lat,
                       input logic [19:0] e1, input logic [19:0] e2, input logic eerr);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.data1 = d1;
    bus.data2 = d2;
    bus.amount = a;
    check({tag, ".in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (hold_valid) begin
      bus.op = 3'd4;
      bus.data1 = 20'h55555;
      bus.data2 = 20'h33333;
      bus.amount = 5'd7;
    end else begin
      bus.in_valid = 1'b0;
    end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result1"}, bus.result1, e1);
    check({tag, ".result2"}, bus.result2, e2);
    check({tag, ".err"}, bus.err, eerr);
    check({tag, ".busy"}, bus.busy, 1);
  endtask

  // Hand the result over; in_valid may still be high to prove nothing is taken on this edge
  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, ".idle_busy"}, bus.busy, 0);
    check({tag, ".idle_out_valid"}, bus.out_valid, 0);
    check({tag, ".idle_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.data1 = 20'd0;
    bus.data2 = 20'd0;
    bus.amount = 5'd0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.result1", bus.result1, 0);
    check("rst.err", bus.err, 0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", bus.in_ready, 1);

    issue("shftl3", 3'd1, 20'h00001, 20'h0, 5'd3, 1'b0, 4, 20'h00008, 20'h0, 1'b0);
    release_result("shftl3");
    issue("rotr1", 3'd2, 20'h00001, 20'h0, 5'd1, 1'b0, 2, 20'h80000, 20'h0, 1'b0);
    release_result("rotr1");
    // in_valid held high with altered operands throughout the run must be ignored
    issue("rotl19", 3'd3, 20'h80001, 20'h0, 5'd19, 1'b1, 20, 20'hC0000, 20'h0, 1'b0);
    release_result("rotl19");
    issue("swap", 3'd4, 20'h12345, 20'hABCDE, 5'd9, 1'b0, 1, 20'hABCDE, 20'h12345, 1'b0);
    release_result("swap");
    issue("swap_eq", 3'd4, 20'h0F0F0, 20'h0F0F0, 5'd0, 1'b0, 1, 20'h0F0F0, 20'h0F0F0, 1'b0);
    release_result("swap_eq");

    issue("shftr25", 3'd0, 20'hFFFFF, 20'h0, 5'd25, 1'b0, 1, 20'h00000, 20'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold.out_valid", bus.out_valid, 1);
      check("hold.result1", bus.result1, 0);
      check("hold.in_ready", bus.in_ready, 0);
    end
    release_result("shftr25");

    issue("illegal6", 3'd6, 20'h13579, 20'h2468A, 5'd3, 1'b0, 1, 20'h0, 20'h0, 1'b1);
    release_result("illegal6");
    issue("shftl0", 3'd1, 20'h5A5A5, 20'h11111, 5'd0, 1'b0, 1, 20'h5A5A5, 20'h0, 1'b0);
    release_result("shftl0");
    issue("rotr20", 3'd2, 20'hFFFFF, 20'h0, 5'd20, 1'b0, 1, 20'h0, 20'h0, 1'b0);
    release_result("rotr20");
    issue("illegal7", 3'd7, 20'hFFFFF, 20'hFFFFF, 5'd5, 1'b0, 1, 20'h0, 20'h0, 1'b1);
    release_result("illegal7");
    issue("rotl18", 3'd3, 20'h00003, 20'h0, 5'd18, 1'b0, 19, 20'hC0000, 20'h0, 1'b0);
    release_result("rotl18");

    // out_ready high before DONE must not shorten or disturb the operation
    bus.out_ready = 1'b1;
    issue("shftr4_rdy", 3'd0, 20'hABCDE, 20'h0, 5'd4, 1'b0, 5, 20'h0ABCD, 20'h0, 1'b0);
    release_result("shftr4_rdy");

    // Reset in the middle of a ROTL by 10 aborts it
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'd3;
    bus.data1 = 20'h12345;
    bus.amount = 5'd10;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort.busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.out_valid", bus.out_valid, 0);
    check("abort.busy", bus.busy, 0);
    check("abort.result1", bus.result1, 0);
    check("abort.result2", bus.result2, 0);
    check("abort.err", bus.err, 0);
    check("abort.in_ready_in_rst", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort.in_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("abort.no_out_valid", seen, 0);
    issue("after_abort", 3'd0, 20'h80000, 20'h0, 5'd4, 1'b0, 5, 20'h08000, 20'h0, 1'b0);
    release_result("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
